// File: rtl/filter_pkg.sv
// ============================================================================
// filter_pkg : run-controller state encoding and parameter limits
// Rev 1.0
// ============================================================================
`default_nettype none

package filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam int LATENCY_MIN   = 1;
  localparam int LATENCY_MAX   = 15;
  localparam int ADDR_BITS_MIN = 1;
  localparam int ADDR_BITS_MAX = 16;

  // Drain counter only ever needs to reach LATENCY_MAX-1.
  localparam int DRAIN_CNT_W = $clog2(LATENCY_MAX + 1);

  function automatic bit params_ok(input int addr_bits, input int latency,
                                   input int num_samples);
    return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX) &&
           (addr_bits >= ADDR_BITS_MIN) && (addr_bits <= ADDR_BITS_MAX) &&
           (num_samples >= 1) && (num_samples <= (1 << addr_bits) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/valid_delay.sv
// ============================================================================
// valid_delay : DEPTH-stage shift pipe tracking which filter outputs are valid
// Rev 1.0
// ============================================================================
`default_nettype none

module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;
  logic [DEPTH-1:0] pipe_shift;

  generate
    if (DEPTH == 1) begin : g_single
      assign pipe_shift = din;
    end else begin : g_multi
      assign pipe_shift = {pipe_q[DEPTH-2:0], din};
    end
  endgenerate

  always_comb begin
    pipe_d = pipe_shift;
    if (clr) begin
      pipe_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/filter_run_ctrl.sv
// ============================================================================
// filter_run_ctrl : sequences ROM reads through the filter into result RAM,
// then lets the user step a review address. Optional: CHECKSUM_EN. Rev 1.0
// ============================================================================
`default_nettype none

module filter_run_ctrl
  import filter_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 8,
  parameter int NUM_SAMPLES = 255,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 filt_en,
  input  logic [DATA_BITS-1:0] filt_out,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic [DATA_BITS-1:0] ram_wdata,
  output logic [ADDR_BITS-1:0] ram_raddr,
  output logic                 busy,
  output logic                 done
`ifdef CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  localparam logic [ADDR_BITS-1:0]   LAST_ADDR  = ADDR_BITS'(NUM_SAMPLES - 1);
  localparam logic [DRAIN_CNT_W-1:0] LAST_DRAIN = DRAIN_CNT_W'(LATENCY - 1);

  run_state_e             state_q, state_d;
  logic [ADDR_BITS-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_BITS-1:0]   ram_waddr_q, ram_waddr_d;
  logic [ADDR_BITS-1:0]   ram_raddr_q, ram_raddr_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   run_start;
  logic                   pipe_out;

  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  valid_delay #(
    .DEPTH (LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (run_start),
    .din  (state_q == ST_RUN),
    .dout (pipe_out)
  );

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    ram_waddr_d = ram_waddr_q;
    ram_raddr_d = ram_raddr_q;
    drain_cnt_d = drain_cnt_q;

    if (pipe_out) begin
      ram_waddr_d = ram_waddr_q + ADDR_BITS'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          rom_addr_d = rom_addr_q + ADDR_BITS'(1);
        end
      end
      // Drain exactly LATENCY cycles so the last valid reaches the RAM.
      ST_DRAIN: begin
        if (drain_cnt_q == LAST_DRAIN) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (step_up && !step_down && (ram_raddr_q != LAST_ADDR)) begin
          ram_raddr_d = ram_raddr_q + ADDR_BITS'(1);
        end else if (step_down && !step_up && (ram_raddr_q != '0)) begin
          ram_raddr_d = ram_raddr_q - ADDR_BITS'(1);
        end
      end
      default: ;
    endcase

    if (run_start) begin
      state_d     = ST_RUN;
      rom_addr_d  = '0;
      ram_waddr_d = '0;
      ram_raddr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      ram_waddr_q <= ram_waddr_d;
      ram_raddr_q <= ram_raddr_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

`ifdef CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (run_start) begin
      checksum_d = '0;
    end else if (pipe_out) begin
      checksum_d = checksum_q + 16'(filt_out);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign rom_addr  = rom_addr_q;
  assign filt_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign busy      = filt_en;
  assign done      = (state_q == ST_DONE);
  assign ram_we    = pipe_out;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = filt_out;
  assign ram_raddr = ram_raddr_q;

endmodule

`default_nettype wire

// File: tb/tb_filter_run_ctrl.sv
// ============================================================================
// tb_filter_run_ctrl : scoreboard bench, 8-sample runs with LATENCY=3
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_filter_run_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int NS  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          step_up = 1'b0;
  logic          step_down = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          filt_en;
  logic [DW-1:0] filt_out;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic          busy;
  logic          done;
`ifdef CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  filter_run_ctrl #(
    .DATA_BITS   (DW),
    .ADDR_BITS   (AW),
    .NUM_SAMPLES (NS),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step_up   (step_up),
    .step_down (step_down),
    .rom_addr  (rom_addr),
    .filt_en   (filt_en),
    .filt_out  (filt_out),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .busy      (busy),
    .done      (done)
`ifdef CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // ROM + filter model: output is f(rom_addr) delayed LAT cycles.
  logic [AW-1:0] h0, h1, h2;
  logic          tie200 = 1'b0;

  function automatic logic [DW-1:0] fsamp(input logic [AW-1:0] a);
    return DW'((32'(a) * 37 + 5) & 32'hFF);
  endfunction

  always @(posedge clk) begin
    h0 <= rom_addr;
    h1 <= h0;
    h2 <= h1;
  end

  assign filt_out = tie200 ? DW'(200) : fsamp(h2);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_rom_addr", 32'(rom_addr), 0);
    check_eq("rst_ram_waddr", 32'(ram_waddr), 0);
    check_eq("rst_ram_raddr", 32'(ram_raddr), 0);
    check_eq("rst_ram_we", 32'(ram_we), 0);
    check_eq("rst_filt_en", 32'(filt_en), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
`ifdef CHECKSUM_EN
    check_eq("rst_checksum", 32'(checksum), 0);
`endif
  endtask

  // Launches a run and checks every cycle through DONE. A start pulse in RUN
  // and step pulses in RUN/DRAIN are injected and must have no effect.
  task automatic run_check();
    logic [31:0] sum = 0;
    exp_t        e;
    int          nwr = 0;
    for (int i = 0; i < NS; i++) begin
      e.addr = AW'(i);
      e.data = tie200 ? DW'(200) : fsamp(AW'(i));
      sb_q.push_back(e);
      sum = (sum + 32'(e.data)) & 32'hFFFF;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k <= NS) check_eq("rom_addr", 32'(rom_addr), 32'(k - 1));
      else         check_eq("rom_addr_hold", 32'(rom_addr), 32'(NS - 1));
      check_eq("filt_en", 32'(filt_en), 32'((k >= 1) && (k <= NS + LAT)));
      check_eq("busy", 32'(busy), 32'((k >= 1) && (k <= NS + LAT)));
      check_eq("ram_we", 32'(ram_we), 32'((k > LAT) && (k <= NS + LAT)));
      check_eq("done", 32'(done), 32'(k >= NS + LAT + 1));
      check_eq("ram_raddr_run", 32'(ram_raddr), 0);
      if (ram_we) begin
        nwr++;
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_write", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("ram_waddr", 32'(ram_waddr), 32'(e.addr));
          check_eq("ram_wdata", 32'(ram_wdata), 32'(e.data));
        end
      end
`ifdef CHECKSUM_EN
      if (k <= LAT) check_eq("checksum_cleared", 32'(checksum), 0);
      if (k >= NS + LAT + 1) check_eq("checksum_done", 32'(checksum), sum);
`endif
      start     = (k == 3);
      step_up   = (k == 5);
      step_down = (k == 10);
      tick();
      start     = 1'b0;
      step_up   = 1'b0;
      step_down = 1'b0;
    end
    check_eq("write_count", 32'(nwr), 32'(NS));
    check_eq("sb_leftover", 32'(sb_q.size()), 0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_vals();
    rst = 1'b1;
    tick();
    check_eq("idle_done", 32'(done), 0);

    run_check();

    // Review stepping in DONE.
    for (int i = 1; i <= 10; i++) begin
      step_up = 1'b1;
      tick();
      step_up = 1'b0;
      check_eq("step_up", 32'(ram_raddr), 32'((i < NS - 1) ? i : NS - 1));
    end
    for (int i = 1; i <= 9; i++) begin
      step_down = 1'b1;
      tick();
      step_down = 1'b0;
      check_eq("step_down", 32'(ram_raddr), 32'((NS - 1 - i > 0) ? NS - 1 - i : 0));
    end
    for (int i = 0; i < 3; i++) begin
      step_up = 1'b1;
      tick();
      step_up = 1'b0;
    end
    check_eq("step_to_3", 32'(ram_raddr), 3);
    step_up   = 1'b1;
    step_down = 1'b1;
    tick();
    step_up   = 1'b0;
    step_down = 1'b0;
    check_eq("step_both", 32'(ram_raddr), 3);
    check_eq("done_hold", 32'(done), 1);

    // Restart from DONE with a constant filter output.
    tie200 = 1'b1;
    run_check();

    // Reset mid-run at rom_addr=4, then a full clean run.
    tie200 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check_eq("pre_rst_rom_addr", 32'(rom_addr), 4);
    rst   = 1'b0;
    start = 1'b1;
    step_up = 1'b1;
    tick();
    start   = 1'b0;
    step_up = 1'b0;
    check_reset_vals();
    rst = 1'b1;
    sb_q.delete();
    tick();
    tick();
    check_eq("post_rst_idle", 32'(busy), 0);
    run_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
